// File: rtl/r_wb_arbiter.sv
// Write-back arbiter feeding the R register: buffers one value each from ALU, AC and MEM,
// issues one aged/priority-ordered write per cycle. Optional forwarding port: RWB_FWD_EN.
module r_wb_arbiter #(
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ac_valid,
    input  logic [DW-1:0] ac_data,
    output logic          ac_ready,
    input  logic          mem_valid,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          stall,
    output logic [DW-1:0] data_out,
    output logic          ALU_write_en,
    output logic          ac_to_r,
    output logic          reg_write_en,
    output logic          busy
`ifdef RWB_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [DW-1:0] fwd_data
`endif
);

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } slot_t;

    // Source index order doubles as priority order: 0=ALU, 1=AC, 2=MEM.
    slot_t         state_q [3];
    slot_t         state_d [3];
    logic [DW-1:0] buf_q   [3];
    logic [DW-1:0] buf_d   [3];
    logic [3:0]    age_q   [3];
    logic [3:0]    age_d   [3];
    logic [DW-1:0] in_data [3];
    logic [2:0]    in_valid;
    logic [2:0]    pend;
    logic [2:0]    aged;
    logic [2:0]    sel;
    logic [2:0]    grant;
    logic [2:0]    ready;
    logic [DW-1:0] gnt_data;
    logic [DW-1:0] data_out_q;
    logic [DW-1:0] data_out_d;
    logic [2:0]    strobe_q;
    logic [2:0]    strobe_d;

    assign in_valid   = {mem_valid, ac_valid, alu_valid};
    assign in_data[0] = alu_data;
    assign in_data[1] = ac_data;
    assign in_data[2] = mem_data;

    always_comb begin
        pend = '0;
        aged = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            pend[i] = (state_q[i] == PENDING);
            aged[i] = pend[i] && (age_q[i] >= 4'(STARVE_LIMIT));
        end
    end

    // Lowest set bit of the candidate set wins; aged sources pre-empt plain pending ones.
    assign sel   = (|aged) ? aged : pend;
    assign grant = stall ? 3'b000 : (sel & (~sel + 3'd1));
    assign ready = ~pend | grant;

    always_comb begin
        gnt_data = buf_q[0];
        if (grant[1]) gnt_data = buf_q[1];
        if (grant[2]) gnt_data = buf_q[2];
    end

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            buf_d[i]   = buf_q[i];
            age_d[i]   = age_q[i];
            if (in_valid[i] && ready[i]) begin
                state_d[i] = PENDING;
                buf_d[i]   = in_data[i];
            end else if (grant[i]) begin
                state_d[i] = EMPTY;
            end
            if (!stall) begin
                if (!pend[i] || grant[i]) age_d[i] = '0;
                else if (age_q[i] != 4'hF) age_d[i] = age_q[i] + 4'd1;
            end
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        strobe_d   = grant;
        if (|grant) data_out_d = gnt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= EMPTY;
                buf_q[i]   <= '0;
                age_q[i]   <= '0;
            end
            data_out_q <= '0;
            strobe_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                buf_q[i]   <= buf_d[i];
                age_q[i]   <= age_d[i];
            end
            data_out_q <= data_out_d;
            strobe_q   <= strobe_d;
        end
    end

    assign alu_ready    = ready[0];
    assign ac_ready     = ready[1];
    assign mem_ready    = ready[2];
    assign data_out     = data_out_q;
    assign ALU_write_en = strobe_q[0];
    assign ac_to_r      = strobe_q[1];
    assign reg_write_en = strobe_q[2];
    assign busy         = |pend;

`ifdef RWB_FWD_EN
    assign fwd_valid = |grant;
    assign fwd_data  = gnt_data;
`endif

endmodule
